// File: rtl/idc_stream_driver.sv
// -----------------------------------------------------------------------------
// idc_stream_driver
//
// Purpose:
//   Transmit-side companion of the IDC core. The host loads an 8x8 pixel frame
//   and an op list into local buffers. A start pulse then replays the frame to
//   the IDC input protocol: 64 back-to-back beats, with the op list riding on
//   the first 15 beats. The driver then captures the IDC output burst of up to
//   16 words into a result buffer that the host reads back combinationally.
//   A watchdog ends the frame if the IDC goes quiet for too long.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   ld_en/ld_sel/        host load strobe, buffer select (0 pix, 1 op),
//   ld_addr/ld_data      address and data (accepted only while idle)
//   start, cg_mode       frame start pulse; cg_mode is latched onto idc_cg_en
//   rd_addr, rd_data     result buffer read port (combinational)
//   busy, done           frame in progress; one-cycle completion pulse
//   timeout, proto_err   sticky status, cleared by the next accepted start
//   idc_in_valid/_data,  IDC input side (registered)
//   idc_op, idc_cg_en
//   idc_out_valid/_data  IDC output side
// -----------------------------------------------------------------------------
module idc_stream_driver #(
  parameter int PIX_W   = 7,
  parameter int OP_W    = 4,
  parameter int N_PIX   = 64,
  parameter int N_OP    = 15,
  parameter int N_OUT   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [5:0]       ld_addr,
  input  logic [PIX_W-1:0] ld_data,
  input  logic             start,
  input  logic             cg_mode,
  input  logic [3:0]       rd_addr,
  output logic [PIX_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             proto_err,
  output logic             idc_in_valid,
  output logic [PIX_W-1:0] idc_in_data,
  output logic [OP_W-1:0]  idc_op,
  output logic             idc_cg_en,
  input  logic             idc_out_valid,
  input  logic [PIX_W-1:0] idc_out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  // Buffers: not reset, contents survive an aborted frame.
  logic [PIX_W-1:0] pix_mem [N_PIX];
  logic [OP_W-1:0]  op_mem  [16];     // entry 15 is never written or sent
  logic [PIX_W-1:0] res_mem [N_OUT];

  state_t           state_q, state_d;
  logic [5:0]       pix_cnt_q, pix_cnt_d;
  logic [4:0]       res_cnt_q, res_cnt_d;
  logic [9:0]       wait_cnt_q, wait_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;
  logic             in_valid_q, in_valid_d;
  logic [PIX_W-1:0] in_data_q, in_data_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             cg_en_q, cg_en_d;

  logic             ld_accept;
  logic             pix_we;
  logic             op_we;
  logic             res_we;
  logic [3:0]       res_waddr;
  logic [5:0]       nxt_cnt;
  logic [OP_W-1:0]  nxt_op;
  logic [PIX_W-1:0] first_pix;
  logic [OP_W-1:0]  first_op;
  logic [9:0]       wait_inc;
  logic             wait_expired;

  assign ld_accept    = ld_en && (state_q == S_IDLE);
  assign pix_we       = ld_accept && !ld_sel;
  assign op_we        = ld_accept && ld_sel && (ld_addr[3:0] != 4'hF);

  assign nxt_cnt      = pix_cnt_q + 6'd1;
  assign nxt_op       = (nxt_cnt < 6'(N_OP)) ? op_mem[nxt_cnt[3:0]] : '0;

  // A load in the same cycle as start lands first; forward it so beat 0
  // carries the freshly loaded value rather than the stale buffer entry.
  assign first_pix    = (pix_we && ld_addr == 6'd0) ? ld_data : pix_mem[0];
  assign first_op     = (op_we && ld_addr[3:0] == 4'd0) ? ld_data[OP_W-1:0] : op_mem[0];

  assign wait_inc     = (wait_cnt_q == 10'h3FF) ? wait_cnt_q : wait_cnt_q + 10'd1;
  // The counter has seen TIMEOUT idle cycles once this cycle is also idle.
  assign wait_expired = (wait_cnt_q == 10'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    res_cnt_d   = res_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
    in_valid_d  = in_valid_q;
    in_data_d   = in_data_q;
    op_d        = op_q;
    cg_en_d     = cg_en_q;
    res_we      = 1'b0;
    res_waddr   = res_cnt_q[3:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SEND;
          pix_cnt_d   = 6'd0;
          res_cnt_d   = 5'd0;
          wait_cnt_d  = 10'd0;
          busy_d      = 1'b1;
          cg_en_d     = cg_mode;
          timeout_d   = 1'b0;
          proto_err_d = 1'b0;
          in_valid_d  = 1'b1;
          in_data_d   = first_pix;
          op_d        = first_op;
        end
      end

      S_SEND: begin
        // The IDC must not answer before it has the whole frame.
        if (idc_out_valid) begin
          proto_err_d = 1'b1;
        end
        if (pix_cnt_q == 6'(N_PIX - 1)) begin
          state_d    = S_WAIT;
          wait_cnt_d = 10'd0;
          in_valid_d = 1'b0;
          in_data_d  = '0;
          op_d       = '0;
        end else begin
          pix_cnt_d = nxt_cnt;
          in_data_d = pix_mem[nxt_cnt];
          op_d      = nxt_op;
        end
      end

      S_WAIT: begin
        if (idc_out_valid) begin
          res_we     = 1'b1;
          res_waddr  = 4'd0;
          res_cnt_d  = 5'd1;
          wait_cnt_d = 10'd0;
          state_d    = S_CAPT;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_CAPT: begin
        if (idc_out_valid) begin
          res_we     = 1'b1;
          res_cnt_d  = res_cnt_q + 5'd1;
          wait_cnt_d = 10'd0;
          if (res_cnt_q == 5'(N_OUT - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      op_q        <= '0;
      cg_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      res_cnt_q   <= res_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      op_q        <= op_d;
      cg_en_q     <= cg_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_we) begin
      pix_mem[ld_addr] <= ld_data;
    end
    if (op_we) begin
      op_mem[ld_addr[3:0]] <= ld_data[OP_W-1:0];
    end
    if (res_we) begin
      res_mem[res_waddr] <= idc_out_data;
    end
  end

  assign rd_data      = res_mem[rd_addr];
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign proto_err    = proto_err_q;
  assign idc_in_valid = in_valid_q;
  assign idc_in_data  = in_data_q;
  assign idc_op       = op_q;
  assign idc_cg_en    = cg_en_q;

endmodule
